rib_wb_bridge: RTL and testbench

RIB_WB_BRIDGE -- requirements
Module: rib_wb_bridge

---
 rtl/rib_wb_bridge.sv | 161 ++++++++++++++++
 tb/tb_rib_wb_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rib_wb_bridge.sv
// Round-robin bridge from NUM_CH RIB requester channels onto one Wishbone classic master port.
// Define WB_REG_RESP_EN to register the Wishbone response, which adds a RESP state and one cycle of latency.
module rib_wb_bridge #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = DATA_W / 8
) (
    input  logic                     clk_core,
    input  logic                     rst_core,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
    input  logic [NUM_CH*SEL_W-1:0]  ch_sel_i,
    output logic [DATA_W-1:0]        ch_rdata_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [NUM_CH-1:0]        ch_err_o,
    output logic                     hold_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [SEL_W-1:0]         wb_sel_o,
    output logic [ADDR_W-1:0]        wb_addr_o,
    output logic [DATA_W-1:0]        wb_data_o,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, gnt_q, gnt_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               any_req, grant;
    logic               tmo, bus_end, bus_ok, bus_err;

    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    // Round-robin: scan starting just after the last granted channel.
    always_comb begin : arb
        int c;
        c       = 0;
        any_req = |ch_req_i;
        gnt_idx = last_q;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = (int'(last_q) + i) % NUM_CH;
            if (ch_req_i[c]) gnt_idx = IDX_W'(c);
        end
    end

    assign grant   = (state_q == S_IDLE) && any_req;
    assign tmo     = (TIMEOUT_CYC != 0) && (int'(cnt_q) == TIMEOUT_CYC - 1);
    assign bus_ok  = wb_ack_i && !wb_err_i;
    assign bus_err = wb_err_i || (tmo && !wb_ack_i);
    assign bus_end = wb_ack_i || wb_err_i || tmo;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_req) state_d = S_BUS;
`ifdef WB_REG_RESP_EN
            S_BUS:  if (bus_end) state_d = S_RESP;
`else
            S_BUS:  if (bus_end) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (grant)                 cnt_d = '0;
        else if (state_q == S_BUS) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            last_q  <= IDX_W'(NUM_CH - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (grant) begin
                last_q  <= gnt_idx;
                gnt_q   <= gnt_idx;
                we_q    <= ch_we_i[gnt_idx];
                sel_q   <= ch_sel_i[gnt_idx*SEL_W +: SEL_W];
                addr_q  <= ch_addr_i[gnt_idx*ADDR_W +: ADDR_W];
                wdata_q <= ch_wdata_i[gnt_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign wb_cyc_o  = (state_q == S_BUS);
    assign wb_stb_o  = wb_cyc_o;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;

`ifdef WB_REG_RESP_EN
    logic              rsp_ok_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            rsp_ok_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else if (state_q == S_BUS && bus_end) begin
            rsp_ok_q   <= bus_ok;
            rsp_err_q  <= bus_err;
            rsp_data_q <= wb_data_i;
        end
    end

    always_comb begin
        ch_done_o  = '0;
        ch_err_o   = '0;
        ch_rdata_o = '0;
        if (state_q == S_RESP) begin
            ch_done_o[gnt_q] = rsp_ok_q;
            ch_err_o[gnt_q]  = rsp_err_q;
            if (rsp_ok_q) ch_rdata_o = rsp_data_q;
        end
    end
`else
    always_comb begin
        ch_done_o  = '0;
        ch_err_o   = '0;
        ch_rdata_o = '0;
        if (state_q == S_BUS) begin
            ch_done_o[gnt_q] = bus_ok;
            ch_err_o[gnt_q]  = bus_err;
            if (bus_ok) ch_rdata_o = wb_data_i;
        end
    end
`endif

    // Stall is purely combinational so it tracks requests even while in reset.
    assign hold_o = |(ch_req_i & ~(ch_done_o | ch_err_o));

endmodule

// File: tb/tb_rib_wb_bridge.sv
// Directed bench for rib_wb_bridge (default build, TIMEOUT_CYC=4): vector table plus
// hand sequences for reset mid-bus and back-to-back round-robin grants.
module tb_rib_wb_bridge;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    logic                     clk_core = 1'b0;
    logic                     rst_core;
    logic [NUM_CH-1:0]        ch_req_i;
    logic [NUM_CH-1:0]        ch_we_i;
    logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
    logic [NUM_CH*DATA_W-1:0] ch_wdata_i;
    logic [NUM_CH*SEL_W-1:0]  ch_sel_i;
    logic [DATA_W-1:0]        ch_rdata_o;
    logic [NUM_CH-1:0]        ch_done_o, ch_err_o;
    logic                     hold_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [SEL_W-1:0]         wb_sel_o;
    logic [ADDR_W-1:0]        wb_addr_o;
    logic [DATA_W-1:0]        wb_data_o, wb_data_i;
    logic                     wb_ack_i, wb_err_i;

    rib_wb_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_addr_i(ch_addr_i),
        .ch_wdata_i(ch_wdata_i), .ch_sel_i(ch_sel_i),
        .ch_rdata_o(ch_rdata_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o), .hold_o(hold_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_core = ~clk_core;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
        ch_we_i[c]                      = we;
        ch_addr_i[c*ADDR_W +: ADDR_W]   = addr;
        ch_wdata_i[c*DATA_W +: DATA_W]  = wdata;
        ch_sel_i[c*SEL_W +: SEL_W]      = sel;
    endtask

    // rcyc: BUS cycle index where ack/err is driven (99 = never); xend: BUS cycle of the pulse
    typedef struct {
        logic [1:0]  req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          rcyc;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        int          xend;
        logic [1:0]  xdone;
        logic [1:0]  xerr;
        logic [31:0] xrdata;
    } vec_t;

    vec_t tv[7];

    initial begin
        tv[0] = '{2'b01, 1'b0, 32'h100, 32'h0,       4'hF, 0,  1'b1, 1'b0, 32'hDEADBEEF, 0, 2'b01, 2'b00, 32'hDEADBEEF};
        tv[1] = '{2'b10, 1'b1, 32'h20,  32'h55AA,    4'h3, 2,  1'b1, 1'b0, 32'h0,        2, 2'b10, 2'b00, 32'h0};
        tv[2] = '{2'b01, 1'b0, 32'h44,  32'h0,       4'hF, 1,  1'b0, 1'b1, 32'h11111111, 1, 2'b00, 2'b01, 32'h0};
        tv[3] = '{2'b10, 1'b0, 32'h48,  32'h0,       4'hF, 0,  1'b1, 1'b1, 32'h22222222, 0, 2'b00, 2'b10, 32'h0};
        tv[4] = '{2'b01, 1'b0, 32'h80,  32'h0,       4'hF, 99, 1'b0, 1'b0, 32'h0,        3, 2'b00, 2'b01, 32'h0};
        tv[5] = '{2'b10, 1'b0, 32'h84,  32'h0,       4'hF, 3,  1'b1, 1'b0, 32'hCAFE0001, 3, 2'b10, 2'b00, 32'hCAFE0001};
        tv[6] = '{2'b01, 1'b1, 32'h90,  32'h0BADF00D, 4'hC, 2, 1'b1, 1'b0, 32'h0,        2, 2'b01, 2'b00, 32'h0};

        rst_core   = 1'b1;
        ch_req_i   = '0;
        ch_we_i    = '0;
        ch_addr_i  = '0;
        ch_wdata_i = '0;
        ch_sel_i   = '0;
        wb_data_i  = '0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;

        // Reset state, and hold following requests while reset is asserted
        repeat (2) @(negedge clk_core);
        #1;
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_addr", wb_addr_o, 32'h0);
        chk("rst_wdata", wb_data_o, 32'h0);
        chk("rst_done", ch_done_o, 2'b00);
        chk("rst_err", ch_err_o, 2'b00);
        chk("rst_rdata", ch_rdata_o, 32'h0);
        chk("rst_hold_idle", hold_o, 1'b0);
        ch_req_i = 2'b01;
        #1;
        chk("rst_hold_req", hold_o, 1'b1);
        ch_req_i = 2'b00;
        @(negedge clk_core);
        rst_core = 1'b0;
        @(negedge clk_core);

        for (int i = 0; i < 7; i++) begin
            int c;
            c = tv[i].req[1] ? 1 : 0;
            set_ch(c, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].sel);
            set_ch(1 - c, ~tv[i].we, ~tv[i].addr, ~tv[i].wdata, ~tv[i].sel);
            ch_req_i = tv[i].req;
            @(negedge clk_core);
            for (int k = 0; k <= tv[i].xend; k++) begin
                wb_ack_i  = (k == tv[i].rcyc) && tv[i].ack;
                wb_err_i  = (k == tv[i].rcyc) && tv[i].err;
                wb_data_i = tv[i].rdata;
                #1;
                chk($sformatf("v%0d_cyc%0d", i, k), wb_cyc_o, 1'b1);
                chk($sformatf("v%0d_stb%0d", i, k), wb_stb_o, 1'b1);
                chk($sformatf("v%0d_we%0d", i, k), wb_we_o, tv[i].we);
                chk($sformatf("v%0d_addr%0d", i, k), wb_addr_o, tv[i].addr);
                chk($sformatf("v%0d_sel%0d", i, k), wb_sel_o, tv[i].sel);
                chk($sformatf("v%0d_wdata%0d", i, k), wb_data_o, tv[i].wdata);
                if (k == tv[i].xend) begin
                    chk($sformatf("v%0d_done", i), ch_done_o, tv[i].xdone);
                    chk($sformatf("v%0d_err", i), ch_err_o, tv[i].xerr);
                    chk($sformatf("v%0d_rdata", i), ch_rdata_o, tv[i].xrdata);
                    chk($sformatf("v%0d_hold_end", i), hold_o, 1'b0);
                end else begin
                    chk($sformatf("v%0d_nodone%0d", i, k), ch_done_o, 2'b00);
                    chk($sformatf("v%0d_noerr%0d", i, k), ch_err_o, 2'b00);
                    chk($sformatf("v%0d_hold%0d", i, k), hold_o, 1'b1);
                end
                @(negedge clk_core);
            end
            ch_req_i = '0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            #1;
            chk($sformatf("v%0d_cyc_off", i), wb_cyc_o, 1'b0);
            chk($sformatf("v%0d_done_off", i), ch_done_o, 2'b00);
            chk($sformatf("v%0d_err_off", i), ch_err_o, 2'b00);
            @(negedge clk_core);
        end

        // Reset mid-BUS after a ch0 grant: bus drops at once, no pulse, arbiter restarts at ch0
        set_ch(0, 1'b0, 32'h300, 32'h0, 4'hF);
        set_ch(1, 1'b0, 32'h400, 32'h0, 4'hF);
        wb_data_i = 32'h5A5A0000;
        ch_req_i  = 2'b01;
        @(negedge clk_core);
        #1;
        chk("mid_cyc_before", wb_cyc_o, 1'b1);
        chk("mid_addr_before", wb_addr_o, 32'h300);
        rst_core = 1'b1;
        #1;
        chk("mid_rst_cyc", wb_cyc_o, 1'b0);
        chk("mid_rst_stb", wb_stb_o, 1'b0);
        chk("mid_rst_addr", wb_addr_o, 32'h0);
        chk("mid_rst_sel", wb_sel_o, 4'h0);
        chk("mid_rst_done", ch_done_o, 2'b00);
        chk("mid_rst_err", ch_err_o, 2'b00);
        chk("mid_rst_hold", hold_o, 1'b1);
        ch_req_i = 2'b11;
        wb_ack_i = 1'b1;
        @(negedge clk_core);
        rst_core = 1'b0;

        // Both channels held, zero-wait ack: ch0, ch1, ch0 with one idle cycle between
        for (int j = 0; j < 6; j++) begin
            logic        xcyc;
            logic [1:0]  xdone;
            logic [31:0] xaddr;
            @(negedge clk_core);
            #1;
            xcyc  = (j % 2 == 0);
            xaddr = (j == 2) ? 32'h400 : 32'h300;
            xdone = (j == 0 || j == 4) ? 2'b01 : ((j == 2) ? 2'b10 : 2'b00);
            chk($sformatf("rr%0d_cyc", j), wb_cyc_o, xcyc);
            chk($sformatf("rr%0d_done", j), ch_done_o, xdone);
            chk($sformatf("rr%0d_err", j), ch_err_o, 2'b00);
            chk($sformatf("rr%0d_hold", j), hold_o, 1'b1);
            if (xcyc) begin
                chk($sformatf("rr%0d_addr", j), wb_addr_o, xaddr);
                chk($sformatf("rr%0d_rdata", j), ch_rdata_o, 32'h5A5A0000);
            end
        end
        ch_req_i = '0;
        wb_ack_i = 1'b0;
        repeat (2) @(negedge clk_core);
        #1;
        chk("final_idle_cyc", wb_cyc_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
